// File: rtl/fir_tap_bram_arbiter.sv
// rtl/fir_tap_bram_arbiter.sv - single-port FIR tap BRAM arbiter between cfg and engine requesters
module fir_tap_bram_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int MAX_WAIT    = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_req_valid,
  output logic                   cfg_req_ready,
  input  logic                   cfg_req_we,
  input  logic [pADDR_WIDTH-1:0] cfg_req_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_req_wdata,
  output logic                   cfg_rsp_valid,
  output logic [pDATA_WIDTH-1:0] cfg_rsp_rdata,
  input  logic                   eng_req_valid,
  output logic                   eng_req_ready,
  input  logic                   eng_req_we,
  input  logic [pADDR_WIDTH-1:0] eng_req_addr,
  input  logic [pDATA_WIDTH-1:0] eng_req_wdata,
  output logic                   eng_rsp_valid,
  output logic [pDATA_WIDTH-1:0] eng_rsp_rdata,
  input  logic                   eng_lock,
  output logic                   addr_err,
  output logic [3:0]             bram_WE,
  output logic                   bram_EN,
  output logic [pDATA_WIDTH-1:0] bram_Di,
  output logic [pADDR_WIDTH-1:0] bram_A,
  input  logic [pDATA_WIDTH-1:0] bram_Do
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LIMIT = pADDR_WIDTH'(4 * Tape_Num);

  logic           lock_q, lock_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           rsp_pending_q, rsp_pending_d;
  logic           rsp_owner_q, rsp_owner_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           addr_err_q, addr_err_d;

  logic                   gnt_cfg, gnt_eng, granted, in_range, access;
  logic                   sel_we;
  logic [pADDR_WIDTH-1:0] sel_addr;
  logic [pDATA_WIDTH-1:0] sel_wdata;
  logic                   rsp_live;

  // Lock outranks the starvation guard; a locked port idles rather than serving cfg.
  always_comb begin
    gnt_cfg = 1'b0;
    gnt_eng = 1'b0;
    if (!axis_rst) begin
      if (lock_q)                                    gnt_eng = eng_req_valid;
      else if (cfg_req_valid && wait_cnt_q == WAIT_SAT) gnt_cfg = 1'b1;
      else if (eng_req_valid)                        gnt_eng = 1'b1;
      else if (cfg_req_valid)                        gnt_cfg = 1'b1;
    end
  end

  assign cfg_req_ready = gnt_cfg;
  assign eng_req_ready = gnt_eng;
  assign granted       = gnt_cfg | gnt_eng;
  assign sel_we        = gnt_eng ? eng_req_we    : cfg_req_we;
  assign sel_addr      = gnt_eng ? eng_req_addr  : cfg_req_addr;
  assign sel_wdata     = gnt_eng ? eng_req_wdata : cfg_req_wdata;
  assign in_range      = (sel_addr < ADDR_LIMIT) && (sel_addr[1:0] == 2'b00);
  assign access        = granted && in_range;

  assign bram_EN = access;
  assign bram_WE = (access && sel_we) ? 4'hF : 4'h0;
  assign bram_A  = access ? sel_addr : '0;
  assign bram_Di = (access && sel_we) ? sel_wdata : '0;

  always_comb begin
    lock_d = lock_q;
    if (gnt_eng) lock_d = eng_lock;

    wait_cnt_d = wait_cnt_q;
    if (!cfg_req_valid || gnt_cfg)          wait_cnt_d = '0;
    else if (!lock_q && wait_cnt_q != WAIT_SAT) wait_cnt_d = wait_cnt_q + 1'b1;

    rsp_pending_d = granted && !sel_we;
    rsp_owner_d   = gnt_eng;
    rsp_zero_d    = !in_range;
    addr_err_d    = granted && !in_range;
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      lock_q        <= 1'b0;
      wait_cnt_q    <= '0;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      lock_q        <= lock_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
      rsp_zero_q    <= rsp_zero_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Reset in the response cycle suppresses the pulse so nothing leaks across reset.
  assign rsp_live      = rsp_pending_q && !axis_rst;
  assign cfg_rsp_valid = rsp_live && !rsp_owner_q;
  assign eng_rsp_valid = rsp_live && rsp_owner_q;
  assign cfg_rsp_rdata = (cfg_rsp_valid && !rsp_zero_q) ? bram_Do : '0;
  assign eng_rsp_rdata = (eng_rsp_valid && !rsp_zero_q) ? bram_Do : '0;
  assign addr_err      = addr_err_q && !axis_rst;

endmodule

// File: tb/tb_fir_tap_bram_arbiter.sv
// tb/tb_fir_tap_bram_arbiter.sv - self-checking bench for fir_tap_bram_arbiter
module tb_fir_tap_bram_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TN = 11;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic axis_rst;
  logic cfg_req_valid, cfg_req_ready, cfg_req_we, cfg_rsp_valid;
  logic [AW-1:0] cfg_req_addr;
  logic [DW-1:0] cfg_req_wdata, cfg_rsp_rdata;
  logic eng_req_valid, eng_req_ready, eng_req_we, eng_rsp_valid, eng_lock;
  logic [AW-1:0] eng_req_addr;
  logic [DW-1:0] eng_req_wdata, eng_rsp_rdata;
  logic addr_err, bram_EN;
  logic [3:0] bram_WE;
  logic [DW-1:0] bram_Di, bram_Do;
  logic [AW-1:0] bram_A;

  always #5 clk = ~clk;

  fir_tap_bram_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TN), .MAX_WAIT(MW)) dut (
    .axis_clk(clk), .axis_rst(axis_rst),
    .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready), .cfg_req_we(cfg_req_we),
    .cfg_req_addr(cfg_req_addr), .cfg_req_wdata(cfg_req_wdata),
    .cfg_rsp_valid(cfg_rsp_valid), .cfg_rsp_rdata(cfg_rsp_rdata),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_req_we(eng_req_we),
    .eng_req_addr(eng_req_addr), .eng_req_wdata(eng_req_wdata),
    .eng_rsp_valid(eng_rsp_valid), .eng_rsp_rdata(eng_rsp_rdata),
    .eng_lock(eng_lock), .addr_err(addr_err),
    .bram_WE(bram_WE), .bram_EN(bram_EN), .bram_Di(bram_Di), .bram_A(bram_A), .bram_Do(bram_Do)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  // Tap BRAM macro stand-in: registered read, full-word write.
  logic [DW-1:0] mem [0:15];
  logic mem_init_q = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_q) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_init_q <= 1'b1;
    end else if (bram_EN) begin
      if (bram_WE == 4'hF) mem[bram_A[5:2]] <= bram_Di;
      else bram_Do <= mem[bram_A[5:2]];
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory image, lock flag, denial count, response queue.
  typedef struct { bit owner_eng; logic [DW-1:0] data; } rsp_t;
  rsp_t rsp_q[$];
  logic [DW-1:0] ref_mem [0:15];
  bit m_lock, m_err;
  int m_wait;
  bit m_gc, m_ge, m_g, m_swe, m_inr;
  logic [AW-1:0] m_sa;
  logic [DW-1:0] m_swd;

  task automatic drive(input bit rst, input bit cv, input bit cwe, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cwd, input bit ev, input bit ewe,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ewd, input bit elk);
    axis_rst = rst; cfg_req_valid = cv; cfg_req_we = cwe; cfg_req_addr = ca; cfg_req_wdata = cwd;
    eng_req_valid = ev; eng_req_we = ewe; eng_req_addr = ea; eng_req_wdata = ewd; eng_lock = elk;
    #3;
  endtask

  task automatic model_check();
    logic [127:0] act, exp;
    bit e_en, e_cr, e_er;
    logic [DW-1:0] e_cd, e_ed;
    m_gc = 0; m_ge = 0;
    if (!axis_rst) begin
      if (m_lock) m_ge = eng_req_valid;
      else if (m_wait == MW && cfg_req_valid) m_gc = 1;
      else if (eng_req_valid) m_ge = 1;
      else if (cfg_req_valid) m_gc = 1;
    end
    m_g   = m_gc || m_ge;
    m_swe = m_ge ? eng_req_we : cfg_req_we;
    m_sa  = m_ge ? eng_req_addr : cfg_req_addr;
    m_swd = m_ge ? eng_req_wdata : cfg_req_wdata;
    m_inr = (int'(m_sa) < 4 * TN) && (int'(m_sa) % 4 == 0);
    e_en = m_g && m_inr;
    e_cr = 0; e_er = 0; e_cd = '0; e_ed = '0;
    if (!axis_rst && rsp_q.size() > 0) begin
      if (rsp_q[0].owner_eng) begin e_er = 1; e_ed = rsp_q[0].data; end
      else begin e_cr = 1; e_cd = rsp_q[0].data; end
    end
    act = {cfg_req_ready, eng_req_ready, bram_EN, bram_WE, bram_A, bram_Di,
           cfg_rsp_valid, cfg_rsp_rdata, eng_rsp_valid, eng_rsp_rdata, addr_err};
    exp = {m_gc, m_ge, e_en, (e_en && m_swe) ? 4'hF : 4'h0, e_en ? m_sa : 12'h0,
           (e_en && m_swe) ? m_swd : 32'h0, e_cr, e_cd, e_er, e_ed, m_err && !axis_rst};
    check("model", act, exp);
  endtask

  task automatic tick();
    if (axis_rst) begin
      m_lock = 0; m_wait = 0; m_err = 0; rsp_q.delete();
    end else begin
      rsp_q.delete();
      m_err = m_g && !m_inr;
      if (m_g && !m_swe) rsp_q.push_back('{m_ge, m_inr ? ref_mem[int'(m_sa) / 4] : 32'h0});
      if (m_g && m_swe && m_inr) ref_mem[int'(m_sa) / 4] = m_swd;
      if (!cfg_req_valid || m_gc) m_wait = 0;
      else if (!m_lock && m_wait < MW) m_wait++;
      if (m_ge) m_lock = eng_lock;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_check();
      tick();
    end
  endtask

  task automatic both_cycle(input string name, input bit elk, input bit exp_c, input bit exp_e);
    drive(0, 1, 0, 12'h00, 0, 1, 0, 12'h04, 0, elk);
    model_check();
    check(name, {126'h0, cfg_req_ready, eng_req_ready}, {126'h0, exp_c, exp_e});
    tick();
  endtask

  typedef struct {
    bit rst; bit cv; bit cwe; logic [AW-1:0] ca; logic [DW-1:0] cwd;
    bit ev; bit ewe; logic [AW-1:0] ea; bit elk;
    bit crdy; bit erdy; bit en; logic [3:0] we; logic [AW-1:0] a;
    bit crsp; logic [DW-1:0] crd; bit ersp; logic [DW-1:0] erd; bit err;
  } vec_t;
  vec_t tbl [13];

  function automatic logic [AW-1:0] rand_addr();
    int r = int'($urandom_range(0, 9));
    if (r < 7) return AW'($urandom_range(0, TN - 1) * 4);
    if (r == 7) return 12'h02C;
    if (r == 8) return 12'h006;
    return AW'($urandom);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    m_lock = 0; m_wait = 0; m_err = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    tbl[0]  = '{1,0,0,12'h00,32'h0,        0,0,12'h00,0, 0,0,0,4'h0,12'h00, 0,32'h0,        0,32'h0,        0};
    tbl[1]  = '{0,0,0,12'h00,32'h0,        0,0,12'h00,0, 0,0,0,4'h0,12'h00, 0,32'h0,        0,32'h0,        0};
    tbl[2]  = '{0,1,1,12'h08,32'hDEADBEEF, 0,0,12'h00,0, 1,0,1,4'hF,12'h08, 0,32'h0,        0,32'h0,        0};
    tbl[3]  = '{0,1,0,12'h08,32'h0,        0,0,12'h00,0, 1,0,1,4'h0,12'h08, 0,32'h0,        0,32'h0,        0};
    tbl[4]  = '{0,0,0,12'h00,32'h0,        0,0,12'h00,0, 0,0,0,4'h0,12'h00, 1,32'hDEADBEEF, 0,32'h0,        0};
    tbl[5]  = '{0,1,1,12'h2C,32'h1234,     0,0,12'h00,0, 1,0,0,4'h0,12'h00, 0,32'h0,        0,32'h0,        0};
    tbl[6]  = '{0,1,0,12'h06,32'h0,        0,0,12'h00,0, 1,0,0,4'h0,12'h00, 0,32'h0,        0,32'h0,        1};
    tbl[7]  = '{0,0,0,12'h00,32'h0,        0,0,12'h00,0, 0,0,0,4'h0,12'h00, 1,32'h0,        0,32'h0,        1};
    tbl[8]  = '{0,0,0,12'h00,32'h0,        0,0,12'h00,0, 0,0,0,4'h0,12'h00, 0,32'h0,        0,32'h0,        0};
    tbl[9]  = '{0,0,0,12'h00,32'h0,        1,0,12'h08,0, 0,1,1,4'h0,12'h08, 0,32'h0,        0,32'h0,        0};
    tbl[10] = '{0,0,0,12'h00,32'h0,        0,0,12'h00,0, 0,0,0,4'h0,12'h00, 0,32'h0,        1,32'hDEADBEEF, 0};
    tbl[11] = '{0,1,0,12'h00,32'h0,        1,0,12'h04,0, 0,1,1,4'h0,12'h04, 0,32'h0,        0,32'h0,        0};
    tbl[12] = '{0,0,0,12'h00,32'h0,        0,0,12'h00,0, 0,0,0,4'h0,12'h00, 0,32'h0,        1,32'hC0DE0001, 0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].cv, tbl[i].cwe, tbl[i].ca, tbl[i].cwd,
            tbl[i].ev, tbl[i].ewe, tbl[i].ea, 32'h0, tbl[i].elk);
      model_check();
      check($sformatf("vec%0d", i),
            {cfg_req_ready, eng_req_ready, bram_EN, bram_WE, bram_EN ? bram_A : 12'h0,
             cfg_rsp_valid, cfg_rsp_valid ? cfg_rsp_rdata : 32'h0,
             eng_rsp_valid, eng_rsp_valid ? eng_rsp_rdata : 32'h0, addr_err},
            {tbl[i].crdy, tbl[i].erdy, tbl[i].en, tbl[i].we, tbl[i].a,
             tbl[i].crsp, tbl[i].crd, tbl[i].ersp, tbl[i].erd, tbl[i].err});
      tick();
    end

    // Fairness: 4 eng grants then 1 cfg grant, twice.
    idle(1);
    for (int i = 0; i < 10; i++) both_cycle($sformatf("fair%0d", i), 0, (i % 5) == 4, (i % 5) != 4);

    // Locked sweep of all taps with cfg waiting throughout.
    idle(1);
    for (int k = 0; k < TN; k++) begin
      drive(0, 1, 0, 12'h00, 0, 1, 0, AW'(4 * k), 0, k < TN - 1);
      model_check();
      check($sformatf("sweep_gnt%0d", k), {126'h0, cfg_req_ready, eng_req_ready}, 128'h1);
      check($sformatf("sweep_rsp%0d", k), {127'h0, eng_rsp_valid}, {127'h0, k > 0});
      tick();
    end
    drive(0, 1, 0, 12'h00, 0, 0, 0, 0, 0, 0);
    model_check();
    check("sweep_release", {125'h0, cfg_req_ready, eng_req_ready, eng_rsp_valid}, 128'h5);
    tick();

    // Lock held with eng silent: port idles, denial count frozen.
    idle(1);
    drive(0, 0, 0, 0, 0, 1, 0, 12'h00, 0, 1);
    model_check();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 12'h00, 0, 0, 0, 0, 0, 0);
      model_check();
      check($sformatf("lockidle%0d", i), {125'h0, cfg_req_ready, eng_req_ready, bram_EN}, 128'h0);
      tick();
    end
    both_cycle("unlock", 0, 0, 1);
    for (int i = 0; i < 5; i++) both_cycle($sformatf("postlock%0d", i), 0, i == 4, i != 4);

    // Reset right after a locking read grant.
    idle(1);
    drive(0, 0, 0, 0, 0, 1, 0, 12'h10, 0, 1);
    model_check();
    tick();
    drive(1, 1, 0, 12'h00, 0, 1, 0, 12'h10, 0, 1);
    model_check();
    check("rst_drop", {124'h0, cfg_req_ready, eng_req_ready, eng_rsp_valid, bram_EN}, 128'h0);
    tick();
    drive(0, 1, 0, 12'h00, 0, 0, 0, 0, 0, 0);
    model_check();
    check("rst_unlock", {125'h0, cfg_req_ready, eng_req_ready, eng_rsp_valid}, 128'h4);
    tick();
    both_cycle("rst_both", 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
            rand_addr(), $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
            rand_addr(), $urandom, $urandom_range(0, 2) == 0);
      model_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
